// File: rtl/gte_irgb_expand.sv
// Expands a packed 15-bit IRGB word into three IR register-file writes (IR1..IR3 = field<<SHIFT).
// Optional macro GTE_ORGB_READBACK_EN adds an o_orgb register holding the last fully committed word.
module gte_irgb_expand #(
   parameter int IR_W    = 16,
   parameter int FIELD_W = 5,
   parameter int SHIFT   = 7
) (
   input  logic                   i_clk,
   input  logic                   i_nRst,
   input  logic                   i_irgbValid,
   input  logic [3*FIELD_W-1:0]   i_irgb,
   output logic                   o_irgbReady,
   output logic                   o_wrEn,
   output logic [1:0]             o_wrAdr,
   output logic [IR_W-1:0]        o_wrData,
   input  logic                   i_wrReady,
   output logic                   o_busy,
   output logic [3*FIELD_W-1:0]   o_orgb
);

   localparam int PAD_W = IR_W - FIELD_W - SHIFT;

   // The encoding doubles as the register-file address of the write being presented.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR_R = 2'd1,
      WR_G = 2'd2,
      WR_B = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [3*FIELD_W-1:0]   capture_q, capture_d;
   logic [FIELD_W-1:0]     field;
   logic                   irgbReady;

   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst) begin
         state_q   <= IDLE;
         capture_q <= '0;
      end else begin
         state_q   <= state_d;
         capture_q <= capture_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      capture_d = capture_q;
      irgbReady = 1'b0;
      case (state_q)
         IDLE: begin
            irgbReady = 1'b1;
            if (i_irgbValid) begin
               capture_d = i_irgb;
               state_d   = WR_R;
            end
         end
         WR_R: begin
            if (i_wrReady) state_d = WR_G;
         end
         WR_G: begin
            if (i_wrReady) state_d = WR_B;
         end
         WR_B: begin
            // Commit cycle also accepts the next word so bursts run without a bubble.
            if (i_wrReady) begin
               irgbReady = 1'b1;
               if (i_irgbValid) begin
                  capture_d = i_irgb;
                  state_d   = WR_R;
               end else begin
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      field = '0;
      case (state_q)
         WR_R:    field = capture_q[FIELD_W-1:0];
         WR_G:    field = capture_q[2*FIELD_W-1:FIELD_W];
         WR_B:    field = capture_q[3*FIELD_W-1:2*FIELD_W];
         default: field = '0;
      endcase
   end

   assign o_irgbReady = irgbReady;
   assign o_wrEn      = (state_q != IDLE);
   assign o_busy      = (state_q != IDLE);
   assign o_wrAdr     = state_q;
   assign o_wrData    = {{PAD_W{1'b0}}, field, {SHIFT{1'b0}}};

`ifdef GTE_ORGB_READBACK_EN
   logic [3*FIELD_W-1:0] orgb_q;
   logic                 commit;

   assign commit = (state_q == WR_B) && i_wrReady;

   // Only a completed sequence updates the readback; an aborted word never reaches it.
   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst) begin
         orgb_q <= '0;
      end else if (commit) begin
         orgb_q <= capture_q;
      end
   end

   assign o_orgb = orgb_q;
`else
   assign o_orgb = '0;
`endif

endmodule

// File: tb/tb_gte_irgb_expand.sv
// Self-checking bench for gte_irgb_expand: a queue of pending register writes serves as the reference model.
module tb_gte_irgb_expand;

   logic        clk;
   logic        i_nRst;
   logic        i_irgbValid;
   logic [14:0] i_irgb;
   logic        o_irgbReady;
   logic        o_wrEn;
   logic [1:0]  o_wrAdr;
   logic [15:0] o_wrData;
   logic        i_wrReady;
   logic        o_busy;
   logic [14:0] o_orgb;

   int compared;
   int mismatched;

   typedef struct {
      logic [1:0]  adr;
      logic [15:0] data;
      logic [14:0] word;
   } wr_t;

   wr_t         pending[$];
   logic [14:0] expOrgb;

   gte_irgb_expand #(.IR_W(16), .FIELD_W(5), .SHIFT(7)) dut (
      .i_clk       (clk),
      .i_nRst      (i_nRst),
      .i_irgbValid (i_irgbValid),
      .i_irgb      (i_irgb),
      .o_irgbReady (o_irgbReady),
      .o_wrEn      (o_wrEn),
      .o_wrAdr     (o_wrAdr),
      .o_wrData    (o_wrData),
      .i_wrReady   (i_wrReady),
      .o_busy      (o_busy),
      .o_orgb      (o_orgb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view of every output, and the model's prediction of it.
   function automatic logic [35:0] obsVec();
      return {o_irgbReady, o_wrEn, o_busy, o_wrAdr, o_wrData, o_orgb};
   endfunction

   function automatic logic [35:0] expVec();
      logic        rdy;
      logic        en;
      logic [1:0]  adr;
      logic [15:0] data;
      rdy  = (pending.size() == 0) || (pending.size() == 1 && i_wrReady);
      en   = (pending.size() != 0);
      adr  = en ? pending[0].adr  : 2'd0;
      data = en ? pending[0].data : 16'd0;
      return {rdy, en, en, adr, data, expOrgb};
   endfunction

   task automatic applyStimulus(input logic v, input logic [14:0] w, input logic r);
      i_irgbValid = v;
      i_irgb      = w;
      i_wrReady   = r;
      @(negedge clk);
   endtask

   // Advances the model across the coming rising edge, then waits for it.
   task automatic advance();
      logic  accept;
      wr_t   e;
      accept = i_irgbValid &&
               ((pending.size() == 0) || (pending.size() == 1 && i_wrReady));
      if (pending.size() != 0 && i_wrReady) begin
`ifdef GTE_ORGB_READBACK_EN
         if (pending[0].adr == 2'd3) expOrgb = pending[0].word;
`endif
         void'(pending.pop_front());
      end
      if (accept) begin
         for (int k = 0; k < 3; k++) begin
            e.adr  = 2'(k + 1);
            e.data = 16'(((int'(i_irgb) >> (5 * k)) % 32) * 128);
            e.word = i_irgb;
            pending.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      i_nRst = 1'b0;
      applyStimulus(1'b0, 15'h0, 1'b0);
      compared++;
      if (obsVec() !== {1'b1, 35'h0}) begin
         mismatched++;
         $display("[TB] FAIL reset_state: got %h expected %h", obsVec(), {1'b1, 35'h0});
      end
      i_nRst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 15'h0, 1'b1);
      compared++;
      if (obsVec() !== expVec()) begin
         mismatched++;
         $display("[TB] FAIL after_reset: got %h expected %h", obsVec(), expVec());
      end
      advance();
   endtask

   task automatic test_full_scale();
      for (int c = 0; c < 6; c++) begin
         applyStimulus(c == 0, (c == 0) ? 15'h7FFF : 15'h0, 1'b1);
         compared++;
         if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL full_scale c%0d: got %h expected %h", c, obsVec(), expVec());
         end
         advance();
      end
   endtask

   task automatic test_field_mix();
      logic [15:0] want[3];
      want[0] = 16'h0F80;
      want[1] = 16'h0900;
      want[2] = 16'h0B00;
      applyStimulus(1'b1, 15'h5A5F, 1'b1);
      advance();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 15'h0, 1'b1);
         compared++;
         if (o_wrEn !== 1'b1 || o_wrAdr !== 2'(c + 1) || o_wrData !== want[c]) begin
            mismatched++;
            $display("[TB] FAIL field_mix IR%0d: got en=%b adr=%0d data=%h expected en=1 adr=%0d data=%h",
                     c + 1, o_wrEn, o_wrAdr, o_wrData, c + 1, want[c]);
         end
         compared++;
         if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL field_mix_model c%0d: got %h expected %h", c, obsVec(), expVec());
         end
         advance();
      end
   endtask

   task automatic test_stall();
      logic rdy[8];
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int c = 0; c < 8; c++) begin
         applyStimulus(c == 0, (c == 0) ? 15'h1234 : 15'h0, rdy[c]);
         compared++;
         if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL stall c%0d: got %h expected %h", c, obsVec(), expVec());
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] want[6];
      want = '{16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0F80};
      applyStimulus(1'b1, 15'h0001, 1'b1);
      advance();
      for (int c = 0; c < 7; c++) begin
         applyStimulus(c == 2, (c == 2) ? 15'h7C00 : 15'h0, 1'b1);
         if (c < 6) begin
            compared++;
            if (o_wrEn !== 1'b1 || o_wrData !== want[c]) begin
               mismatched++;
               $display("[TB] FAIL back_to_back w%0d: got en=%b data=%h expected en=1 data=%h",
                        c, o_wrEn, o_wrData, want[c]);
            end
         end
         compared++;
         if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL back_to_back_model c%0d: got %h expected %h", c, obsVec(), expVec());
         end
         advance();
      end
   endtask

   task automatic test_busy_ignore();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(c == 0 || c == 1 || c == 2 || c == 5, 15'($urandom), c != 2);
         compared++;
         if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL busy_ignore c%0d: got %h expected %h", c, obsVec(), expVec());
         end
         advance();
      end
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 15'h0, 1'b1);
         advance();
      end
      pending.delete();
   endtask

   task automatic test_reset_abort();
      applyStimulus(1'b1, 15'h2A55, 1'b1);
      advance();
      applyStimulus(1'b0, 15'h0, 1'b1);
      advance();
      applyStimulus(1'b0, 15'h0, 1'b0);
      compared++;
      if (o_wrAdr !== 2'd2 || o_wrEn !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL abort_setup: got en=%b adr=%0d expected en=1 adr=2", o_wrEn, o_wrAdr);
      end
      i_nRst = 1'b0;
      #1;
      pending.delete();
      expOrgb = '0;
      compared++;
      if (o_wrEn !== 1'b0 || o_busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_async: got en=%b busy=%b expected en=0 busy=0", o_wrEn, o_busy);
      end
      @(posedge clk);
      #2;
      i_nRst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 15'h0, 1'b1);
      compared++;
      if (obsVec() !== expVec()) begin
         mismatched++;
         $display("[TB] FAIL abort_release: got %h expected %h", obsVec(), expVec());
      end
      advance();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         applyStimulus(1'($urandom_range(0, 1)), 15'($urandom), $urandom_range(0, 9) < 7);
         compared++;
         if (obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL random c%0d: got %h expected %h", c, obsVec(), expVec());
         end
         advance();
      end
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      expOrgb     = '0;
      i_nRst      = 1'b0;
      i_irgbValid = 1'b0;
      i_irgb      = '0;
      i_wrReady   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_full_scale();
      test_field_mix();
      test_stall();
      test_back_to_back();
      test_busy_ignore();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
